// File: rtl/lsu_pipelined_if.sv
// rtl/lsu_pipelined_if.sv - core data bus between the LSU (master) and memory (slave)
//
// Purpose: groups the split read/write core-bus channels into one bundle.
// Ports (signals):
//   read address : rd_addr, rd_size, rd_addr_valid, rd_addr_ready
//   read data    : rd_data, rd_resp, rd_valid, rd_ready
//   write address: wr_addr, wr_size, wr_addr_valid, wr_addr_ready
//   write data   : wr_data, wr_strobe, wr_data_valid, wr_data_ready
//   write resp   : wr_resp_error, wr_resp_valid, wr_resp_ready
// Encodings: size 2 = CB_WORD; resp 0 = CB_OKAY, 2 = CB_SLVERR.
interface lsu_pipelined_if;
   logic [31:0] rd_addr;
   logic [1:0]  rd_size;
   logic        rd_addr_valid;
   logic        rd_addr_ready;
   logic [31:0] rd_data;
   logic [1:0]  rd_resp;
   logic        rd_valid;
   logic        rd_ready;

   logic [31:0] wr_addr;
   logic [1:0]  wr_size;
   logic        wr_addr_valid;
   logic        wr_addr_ready;
   logic [31:0] wr_data;
   logic [3:0]  wr_strobe;
   logic        wr_data_valid;
   logic        wr_data_ready;
   logic [1:0]  wr_resp_error;
   logic        wr_resp_valid;
   logic        wr_resp_ready;

   modport master (
      output rd_addr, rd_size, rd_addr_valid, rd_ready,
      input  rd_addr_ready, rd_data, rd_resp, rd_valid,
      output wr_addr, wr_size, wr_addr_valid, wr_data, wr_strobe, wr_data_valid, wr_resp_ready,
      input  wr_addr_ready, wr_data_ready, wr_resp_error, wr_resp_valid
   );

   modport slave (
      input  rd_addr, rd_size, rd_addr_valid, rd_ready,
      output rd_addr_ready, rd_data, rd_resp, rd_valid,
      input  wr_addr, wr_size, wr_addr_valid, wr_data, wr_strobe, wr_data_valid, wr_resp_ready,
      output wr_addr_ready, wr_data_ready, wr_resp_error, wr_resp_valid
   );
endinterface

// File: rtl/lsu_pipelined.sv
// rtl/lsu_pipelined.sv - pipelined in-order load/store unit with pending queue
//
// Purpose: accepts up to MAX_OUTSTANDING in-order loads/stores from EXE, issues
// them on the core bus, retires them in order with formatted load data, and
// traps misaligned or bus-faulted accesses.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   lsu_op_typ..rd_addr request from EXE (op 0=none 1=load 2=store; width is
//                      funct3: 0=B 1=H 2=W 4=BU 5=HU), held while lsu_bp=1
//   lsu_bp             back-pressure to EXE
//   wb_*               retiring operation (valid for one cycle per retire)
//   lsu_data           formatted load data, 0 when the retiring op is not a load
//   bus                core-bus master
//   trap_ld_*/trap_st_* load/store fault or misalign, mtval = access address
module lsu_pipelined #(
   parameter int MAX_OUTSTANDING  = 2,
   parameter int SUPPORT_WR_RESP  = 1,
   parameter int SUPPORT_MISALIGN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  lsu_op_typ,
   input  logic [2:0]  lsu_width,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   input  logic [4:0]  lsu_rd_addr,
   output logic        lsu_bp,
   output logic        wb_valid,
   output logic [1:0]  wb_op_typ,
   output logic [2:0]  wb_width,
   output logic [31:0] wb_addr,
   output logic [31:0] wb_wdata,
   output logic [4:0]  wb_rd_addr,
   output logic [31:0] lsu_data,
   lsu_pipelined_if.master bus,
   output logic        trap_ld_active,
   output logic [31:0] trap_ld_mtval,
   output logic        trap_st_active,
   output logic [31:0] trap_st_mtval
);
   localparam int DEPTH = MAX_OUTSTANDING;
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int SLOTS = 1 << IW;

   typedef struct packed {
      logic        is_store;
      logic [2:0]  width;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd_addr;
      logic        aligned;
   } entry_t;

   entry_t            q [SLOTS];
   logic [SLOTS-1:0]  sent;
   logic [CW-1:0]     wr_ptr, rd_ptr, count;
   logic              lock_ld, lock_st;
   logic [31:0]       lock_addr;

   logic [IW-1:0]     wr_idx, rd_idx, data_idx, scan_idx;
   logic              data_found, data_hs, head_data_hs;
   logic              req_ld, req_st, misal, full, conflict, can_try, accept, retire;
   entry_t            head;
   entry_t            dent;
   logic [3:0]        st_mask;
   logic [31:0]       rd_shift;

   function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
      return (p == CW'(DEPTH - 1)) ? '0 : p + CW'(1);
   endfunction

   assign wr_idx = wr_ptr[IW-1:0];
   assign rd_idx = rd_ptr[IW-1:0];
   assign head   = q[rd_idx];

   assign req_ld = (lsu_op_typ == 2'd1);
   assign req_st = (lsu_op_typ == 2'd2);
   assign misal  = (SUPPORT_MISALIGN != 0) &&
                   (((lsu_width[1:0] == 2'b01) && lsu_addr[0]) ||
                    ((lsu_width[1:0] == 2'b10) && (lsu_addr[1:0] != 2'b00)));
   assign full   = (count == CW'(DEPTH));
   // Conflict rule keeps the queue single-typed, so checking the head suffices.
   assign conflict = (count != '0) && (head.is_store != req_st);
   assign can_try  = !rst && (req_ld || req_st) && !full && !conflict;

   // Address channels; the lock keeps a raised valid and its address stable.
   assign bus.rd_addr_valid = !rst && (lock_ld || (can_try && req_ld && !misal));
   assign bus.wr_addr_valid = !rst && (lock_st || (can_try && req_st && !misal));
   assign bus.rd_addr       = lock_ld ? lock_addr : {lsu_addr[31:2], 2'b00};
   assign bus.wr_addr       = lock_st ? lock_addr : {lsu_addr[31:2], 2'b00};
   assign bus.rd_size       = 2'd2;
   assign bus.wr_size       = 2'd2;
   assign bus.rd_ready      = 1'b1;
   assign bus.wr_resp_ready = 1'b1;

   assign accept = can_try &&
                   (misal ||
                    (req_ld && bus.rd_addr_valid && bus.rd_addr_ready) ||
                    (req_st && bus.wr_addr_valid && bus.wr_addr_ready));
   assign lsu_bp = !rst && (req_ld || req_st) && !accept;

   // Oldest queued aligned store whose data beat has not been sent yet.
   always_comb begin
      data_found = 1'b0;
      data_idx   = '0;
      scan_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = rd_idx + IW'(i);
         if (!data_found && (CW'(i) < count) && q[scan_idx].is_store &&
             q[scan_idx].aligned && !sent[scan_idx]) begin
            data_found = 1'b1;
            data_idx   = scan_idx;
         end
      end
   end

   assign dent    = q[data_idx];
   assign st_mask = (dent.width[1:0] == 2'b00) ? 4'b0001 :
                    (dent.width[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
   assign bus.wr_strobe     = st_mask << dent.addr[1:0];
   assign bus.wr_data       = (dent.wdata << {dent.addr[1:0], 3'b000}) &
                              {{8{bus.wr_strobe[3]}}, {8{bus.wr_strobe[2]}},
                               {8{bus.wr_strobe[1]}}, {8{bus.wr_strobe[0]}}};
   assign bus.wr_data_valid = !rst && data_found;
   assign data_hs           = bus.wr_data_valid && bus.wr_data_ready;
   assign head_data_hs      = data_hs && (data_idx == rd_idx);

   // Retire from the head only; misaligned entries retire as soon as they lead.
   always_comb begin
      retire = 1'b0;
      if (!rst && (count != '0)) begin
         if (!head.aligned)
            retire = 1'b1;
         else if (!head.is_store)
            retire = bus.rd_valid;
         else
            retire = (SUPPORT_WR_RESP != 0) ? bus.wr_resp_valid : head_data_hs;
      end
   end

   assign rd_shift = bus.rd_data >> {head.addr[1:0], 3'b000};
   always_comb begin
      lsu_data = '0;
      if (retire && !head.is_store && head.aligned) begin
         case (head.width)
            3'd0:    lsu_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd1:    lsu_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd4:    lsu_data = {24'd0, rd_shift[7:0]};
            3'd5:    lsu_data = {16'd0, rd_shift[15:0]};
            default: lsu_data = rd_shift;
         endcase
      end
   end

   assign wb_valid   = retire;
   assign wb_op_typ  = retire ? (head.is_store ? 2'd2 : 2'd1) : 2'd0;
   assign wb_width   = retire ? head.width   : 3'd0;
   assign wb_addr    = retire ? head.addr    : 32'd0;
   assign wb_wdata   = retire ? head.wdata   : 32'd0;
   assign wb_rd_addr = retire ? head.rd_addr : 5'd0;

   assign trap_ld_active = retire && !head.is_store &&
                           (!head.aligned || (bus.rd_resp != 2'd0));
   assign trap_st_active = retire && head.is_store &&
                           (!head.aligned ||
                            ((SUPPORT_WR_RESP != 0) && (bus.wr_resp_error != 2'd0)));
   assign trap_ld_mtval  = trap_ld_active ? head.addr : 32'd0;
   assign trap_st_mtval  = trap_st_active ? head.addr : 32'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         lock_ld   <= 1'b0;
         lock_st   <= 1'b0;
         lock_addr <= '0;
      end else begin
         if (accept) begin
            q[wr_idx]    <= '{is_store: req_st, width: lsu_width, addr: lsu_addr,
                              wdata: lsu_wdata, rd_addr: lsu_rd_addr, aligned: !misal};
            sent[wr_idx] <= 1'b0;
            wr_ptr       <= ptr_inc(wr_ptr);
         end
         if (data_hs)
            sent[data_idx] <= 1'b1;
         if (retire)
            rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(accept) - CW'(retire);

         if (bus.rd_addr_valid && !bus.rd_addr_ready) begin
            lock_ld   <= 1'b1;
            lock_addr <= bus.rd_addr;
         end else if (bus.rd_addr_ready) begin
            lock_ld <= 1'b0;
         end
         if (bus.wr_addr_valid && !bus.wr_addr_ready) begin
            lock_st   <= 1'b1;
            lock_addr <= bus.wr_addr;
         end else if (bus.wr_addr_ready) begin
            lock_st <= 1'b0;
         end
      end
   end
endmodule

// File: doc/lsu_pipelined.md
# lsu_pipelined

Parametrised load/store unit between the EXE stage and the core data bus; successor to the single-outstanding LSU. Accepts up to `MAX_OUTSTANDING` in-order memory operations, tracks them in a pending queue and formats load data (byte-lane shift plus sign/zero extension) before write-back. Detects misaligned accesses locally and reports them as traps without issuing a bus transaction.

## Interface

**Parameters**
- `MAX_OUTSTANDING`, default 2: pending-queue depth; power of two, range 1–8.
- `SUPPORT_WR_RESP`, default 1: 1 = a store retires on `wr_resp_valid`; 0 = it retires on the `wr_data` handshake.
- `SUPPORT_MISALIGN`, default 1: 1 = misaligned H/W accesses trap locally; 0 = bus issued with aligned address, low bits ignored.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `lsu_i` in `s_lsu_op_t`: request from EXE (`op_typ`, `width`, `addr`, `wdata`, `rd_addr`). Held stable by EXE while `lsu_bp_o`=1.
- `lsu_bp_o` out 1: back-pressure to EXE.
- `wb_valid_o` out 1: one operation retires this cycle.
- `wb_lsu_o` out `s_lsu_op_t`: the retiring operation.
- `lsu_data_o` out `rdata_t`: formatted load data; 0 when the retiring op is not a load.
- `data_cb_mosi_o` out `s_cb_mosi_t`: core-bus master signals.
- `data_cb_miso_i` in `s_cb_miso_t`: core-bus slave signals.
- `trap_info_ld_o` out `s_trap_info_t`: load fault or misalign; `active`, `mtval`=addr.
- `trap_info_st_o` out `s_trap_info_t`: store fault or misalign; `active`, `mtval`=addr.

## Operation

- **Pending queue:** circular FIFO of `MAX_OUTSTANDING` entries holding op, aligned flag and data-sent flag. Wr/rd pointers and `count` are clog2+1 bits; wrap is modulo depth.
- **Accept:** `lsu_i.op_typ`≠NO_LSU, queue not full, no type conflict, and the address handshake completes (`*_addr_valid` & `*_addr_ready`) in the same cycle → push the entry.
  - Misaligned ops (H with addr[0]=1; W with addr[1:0]≠0) push with no bus address phase.
- **Type conflict:** a load is not issued while any store is pending, and vice versa. The bus keeps no cross-channel order.
- **Address phase:** `rd/wr_addr` = {addr[31:2],2'b0}, size `CB_WORD`. `*_addr_valid` is held high with constant address until ready.
  - Once valid rises, the address is latched internally (lock). Valid does not drop before ready.
- **Store data phase:** the oldest store without data-sent drives `wr_data_valid`.
  - `wr_strobe` = width mask (B=0001, H=0011, W=1111) << addr[1:0].
  - `wr_data` = wdata << 8·addr[1:0], with non-strobed bytes zeroed.
  - Handshake sets data-sent.
- **Retire:** head entry only, at most one per cycle.
  - Load: on `rd_valid`.
  - Store: on `wr_resp_valid`, or on data handshake when `SUPPORT_WR_RESP`=0.
  - Misaligned: head reaches it → retire immediately, no bus activity.
  - Retire pops the queue; accept and retire in the same cycle leave `count` unchanged.
- **Load formatting:** shift `rd_data` right by 8·addr[1:0], then:
  - B: sign-extend bit 7; BU: zero-extend.
  - H: sign-extend bit 15; HU: zero-extend.
  - W: pass through.
- **Traps:** `trap_info_*_o.active`=1 for one cycle at retire when `rd_resp`/`wr_resp_error`≠CB_OKAY, or when the retiring op is misaligned. The trap is still a retire (`wb_valid_o`=1).
- `rd_ready` and `wr_resp_ready` are tied to 1.

## Timing

- **Reset:**
  - Queue empty, lock cleared.
  - `lsu_bp_o`=0; `wb_valid_o`=0; `lsu_data_o`=0.
  - All mosi valids=0, `rd_ready`=`wr_resp_ready`=1.
  - Traps inactive.
  - Reset mid-transaction discards all pending entries; late bus responses after reset are ignored because the queue is empty.
- **Latency:** address valid is combinational from `lsu_i` in the accept cycle.
  - Load with `rd_valid` one cycle after the address handshake → `wb_valid_o` in that cycle; `lsu_data_o` is combinational from `rd_data`.
  - Back-to-back accepts are possible every cycle until full.
- **`lsu_bp_o`** = op present & ~(accept this cycle).
- **Full:** `count`=MAX_OUTSTANDING blocks accept, except that a retire in the same cycle does not free the slot until the next cycle. Full means no same-cycle bypass.
- **Empty:** a retire is never signalled; spurious `rd_valid`/`wr_resp_valid` is ignored.
- **Simultaneous events:**
  - Store address and data handshakes may occur in the same cycle for the same entry.
  - A trap and a new accept may coincide.

## Test plan

- **Aligned load:** LW 0x100, memory returns 0x8899AABB one cycle later → `wb_valid_o`=1, `lsu_data_o`=0x8899AABB, queue empty afterwards.
- **Byte sign/zero load:** LB at 0x103 with rd_data 0x80112233 → 0xFFFFFF80; LBU at the same address → 0x00000080.
- **Store lanes:** SH at 0x102, wdata 0x0000BEEF → `wr_strobe`=1100, `wr_data`=0xBEEF0000, `wr_addr`=0x100.
- **Full/back-pressure:** `MAX_OUTSTANDING`=2, three LWs with `rd_valid` withheld → third sees `lsu_bp_o`=1. Release one response → third accepted the next cycle, and responses retire in order.
- **Misalign:** LW at 0x102 → no `rd_addr_valid`; `trap_info_ld_o.active`=1 with `mtval`=0x102 in the retire cycle.
- **Fault and reset:**
  - Store with `wr_resp_error`=CB_SLVERR → `trap_info_st_o.active` for one cycle.
  - Assert `rst` with two loads pending → all outputs return to reset values the next cycle.
